// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data memory controller slice.
// Optional feature macro: DATA_MEM_CTRL_CLEAR_EN (zero-fill RAM after reset).
package data_mem_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    HOST  = 2'd1,
    START = 2'd2,
    RUN   = 2'd3
  } dmem_state_e;

  // Matrix header word addresses used by host software and processor code
  localparam int unsigned HDR_A       = 0;
  localparam int unsigned HDR_B       = 1;
  localparam int unsigned HDR_C       = 2;
  localparam int unsigned HDR_P_START = 3;
  localparam int unsigned HDR_Q_START = 4;
  localparam int unsigned HDR_R_START = 5;
  localparam int unsigned HDR_P_END   = 6;
  localparam int unsigned HDR_Q_END   = 7;
  localparam int unsigned HDR_R_END   = 8;

  // RAM word width: one REG_WIDTH lane per core
  function automatic int unsigned dw_of(input int unsigned reg_width,
                                        input int unsigned core_count);
    return reg_width * core_count;
  endfunction

  // Address width, never below 1 bit
  function automatic int unsigned addr_w_of(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dmem_sp_ram.sv
// Single-port synchronous RAM, DEPTH x DW, one-cycle registered read.
// A write and a read to the same address in one cycle return the old word.
module dmem_sp_ram #(
  parameter int unsigned DEPTH  = 4096,
  parameter int unsigned DW     = 48,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DW-1:0]     wdata,
  output logic [DW-1:0]     rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Storage array with read-before-write output register
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: arbitrates one RAM port between the host
// (preload / dump) and the processor, sequences start/run/done and
// counts run cycles.
// Optional feature macro: DATA_MEM_CTRL_CLEAR_EN zero-fills every RAM
// word after reset before the host port opens.
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter  int unsigned REG_WIDTH      = 12,
  parameter  int unsigned CORE_COUNT     = 4,
  parameter  int unsigned DATA_MEM_DEPTH = 4096,
  parameter  int unsigned CYC_W          = 32,
  localparam int unsigned DW             = dw_of(REG_WIDTH, CORE_COUNT),
  localparam int unsigned ADDR_W         = addr_w_of(DATA_MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              host_wr_valid,
  input  logic [ADDR_W-1:0] host_wr_addr,
  input  logic [DW-1:0]     host_wr_data,
  output logic              host_wr_ready,
  input  logic              host_rd_req,
  input  logic [ADDR_W-1:0] host_rd_addr,
  output logic              host_rd_ready,
  output logic              host_rd_valid,
  output logic [DW-1:0]     host_rd_data,
  input  logic              host_go,
  output logic              busy,
  output logic [CYC_W-1:0]  run_cycles,
  output logic              start,
  input  logic              ready,
  input  logic              done,
  input  logic [ADDR_W-1:0] dataMemAddr,
  input  logic              DataMemWrEn,
  input  logic [DW-1:0]     ProcessorDataOut,
  output logic [DW-1:0]     ProcessorDataIn
);

  dmem_state_e       state_q, state_d;
  logic              hrd_valid_q;
  logic              prd_valid_q;
  logic [CYC_W-1:0]  run_cycles_q;
  logic              go_accept;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DW-1:0]     ram_wdata;
  logic [DW-1:0]     ram_rdata;

`ifdef DATA_MEM_CTRL_CLEAR_EN
  localparam dmem_state_e RESET_STATE = CLEAR;
  logic [ADDR_W-1:0] clear_addr_q;
`else
  localparam dmem_state_e RESET_STATE = HOST;
`endif

  assign go_accept = (state_q == HOST) && host_go && !host_wr_valid;

  // State register
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
`ifdef DATA_MEM_CTRL_CLEAR_EN
      CLEAR: if (clear_addr_q == ADDR_W'(DATA_MEM_DEPTH - 1)) state_d = HOST;
`else
      CLEAR: state_d = HOST;
`endif
      HOST:  if (go_accept) state_d = START;
      START: if (!ready)    state_d = RUN;
      RUN:   if (done)      state_d = HOST;
      default: state_d = RESET_STATE;
    endcase
  end

`ifdef DATA_MEM_CTRL_CLEAR_EN
  // Zero-fill address walker; restarts from 0 on every reset
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      clear_addr_q <= '0;
    end else if (state_q == CLEAR) begin
      clear_addr_q <= clear_addr_q + ADDR_W'(1);
    end
  end
`endif

  // RAM port owner select: clear walker, host (write wins) or processor
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = host_rd_addr;
    ram_wdata = host_wr_data;
    unique case (state_q)
`ifdef DATA_MEM_CTRL_CLEAR_EN
      CLEAR: begin
        ram_we    = 1'b1;
        ram_addr  = clear_addr_q;
        ram_wdata = '0;
      end
`endif
      HOST: begin
        if (host_wr_valid) begin
          ram_we   = 1'b1;
          ram_addr = host_wr_addr;
        end
      end
      RUN: begin
        ram_we    = DataMemWrEn;
        ram_addr  = dataMemAddr;
        ram_wdata = ProcessorDataOut;
      end
      default: ;
    endcase
  end

  dmem_sp_ram #(
    .DEPTH  (DATA_MEM_DEPTH),
    .DW     (DW),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Read-return qualifiers: mark which requester owns next cycle's RAM data
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      hrd_valid_q <= 1'b0;
      prd_valid_q <= 1'b0;
    end else begin
      hrd_valid_q <= (state_q == HOST) && host_rd_req && !host_wr_valid;
      prd_valid_q <= (state_q == RUN);
    end
  end

  // Run-cycle counter: cleared on go, saturating count of RUN cycles
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      run_cycles_q <= '0;
    end else if (go_accept) begin
      run_cycles_q <= '0;
    end else if ((state_q == RUN) && (run_cycles_q != '1)) begin
      run_cycles_q <= run_cycles_q + CYC_W'(1);
    end
  end

  assign host_wr_ready   = (state_q == HOST);
  assign host_rd_ready   = (state_q == HOST) && !host_wr_valid;
  assign busy            = (state_q != HOST);
  assign start           = (state_q == START);
  assign run_cycles      = run_cycles_q;
  // Outputs are gated to 0 unless the returning word belongs to that side
  assign host_rd_valid   = hrd_valid_q;
  assign host_rd_data    = hrd_valid_q ? ram_rdata : '0;
  assign ProcessorDataIn = prd_valid_q ? ram_rdata : '0;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: randomized host and processor
// traffic against an associative-array memory model, with expected read
// returns queued by the drivers and checked by an independent monitor.
module tb_data_mem_ctrl;

  localparam int unsigned RW    = 12;
  localparam int unsigned CC    = 4;
  localparam int unsigned DEPTH = 4096;
  localparam int unsigned CW    = 32;
  localparam int unsigned DW    = RW * CC;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rstN;
  logic          host_wr_valid;
  logic [AW-1:0] host_wr_addr;
  logic [DW-1:0] host_wr_data;
  logic          host_wr_ready;
  logic          host_rd_req;
  logic [AW-1:0] host_rd_addr;
  logic          host_rd_ready;
  logic          host_rd_valid;
  logic [DW-1:0] host_rd_data;
  logic          host_go;
  logic          busy;
  logic [CW-1:0] run_cycles;
  logic          start;
  logic          ready;
  logic          done;
  logic [AW-1:0] dataMemAddr;
  logic          DataMemWrEn;
  logic [DW-1:0] ProcessorDataOut;
  logic [DW-1:0] ProcessorDataIn;

  data_mem_ctrl #(
    .REG_WIDTH      (RW),
    .CORE_COUNT     (CC),
    .DATA_MEM_DEPTH (DEPTH),
    .CYC_W          (CW)
  ) dut (
    .clk              (clk),
    .rstN             (rstN),
    .host_wr_valid    (host_wr_valid),
    .host_wr_addr     (host_wr_addr),
    .host_wr_data     (host_wr_data),
    .host_wr_ready    (host_wr_ready),
    .host_rd_req      (host_rd_req),
    .host_rd_addr     (host_rd_addr),
    .host_rd_ready    (host_rd_ready),
    .host_rd_valid    (host_rd_valid),
    .host_rd_data     (host_rd_data),
    .host_go          (host_go),
    .busy             (busy),
    .run_cycles       (run_cycles),
    .start            (start),
    .ready            (ready),
    .done             (done),
    .dataMemAddr      (dataMemAddr),
    .DataMemWrEn      (DataMemWrEn),
    .ProcessorDataOut (ProcessorDataOut),
    .ProcessorDataIn  (ProcessorDataIn)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  typedef struct {
    int unsigned   due;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          hq[$];
  exp_t          pq[$];
  logic [DW-1:0] model [int unsigned];
  int unsigned   known[$];
  bit            clear_mode;
  bit            exp_host;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [DW-1:0] model_rd(input int unsigned a);
    if (model.exists(a)) return model[a];
    return '0;
  endfunction

  function automatic bit is_known(input int unsigned a);
    return clear_mode || model.exists(a);
  endfunction

  function automatic void model_wr(input int unsigned a, input logic [DW-1:0] d);
    if (!model.exists(a)) known.push_back(a);
    model[a] = d;
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[DW-1:0];
  endfunction

  // Monitor: host read returns and processor read returns vs queued expectations
  always @(negedge clk) begin
    bit   hv;
    exp_t e;
    while (hq.size() > 0 && hq[0].due < cyc) begin
      e = hq.pop_front();
      chk("host_rd_valid_late", 64'(host_rd_valid), 64'(1));
    end
    hv = (hq.size() > 0) && (hq[0].due == cyc);
    if (hv || host_rd_valid) begin
      chk("host_rd_valid", 64'(host_rd_valid), 64'(hv));
      if (hv) begin
        e = hq.pop_front();
        chk("host_rd_data", 64'(host_rd_data), 64'(e.data));
      end
    end
    while (pq.size() > 0 && pq[0].due < cyc) void'(pq.pop_front());
    if (pq.size() > 0 && pq[0].due == cyc) begin
      e = pq.pop_front();
      chk("proc_rd_data", 64'(ProcessorDataIn), 64'(e.data));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One host-side cycle; called at posedge+1, returns at the next posedge+1
  task automatic drive_host(input bit wr, input int unsigned wa, input logic [DW-1:0] wd,
                            input bit rd, input int unsigned ra, input bit go);
    bit rdy;
    exp_t e;
    host_wr_valid = wr;
    host_wr_addr  = AW'(wa);
    host_wr_data  = wd;
    host_rd_req   = rd;
    host_rd_addr  = AW'(ra);
    host_go       = go;
    rdy = exp_host && !wr;
    if (rd && rdy && is_known(ra)) begin
      e.due  = cyc + 1;
      e.data = model_rd(ra);
      hq.push_back(e);
    end else if (rd && rdy) begin
      e.due  = cyc + 1;
      e.data = host_rd_data;
    end
    if (wr && exp_host) model_wr(wa, wd);
    @(negedge clk);
    chk("host_wr_ready", 64'(host_wr_ready), 64'(exp_host));
    chk("host_rd_ready", 64'(host_rd_ready), 64'(rdy));
    tick();
    if (go && !wr && exp_host) exp_host = 1'b0;
  endtask

  task automatic host_idle();
    drive_host(1'b0, 0, '0, 1'b0, 0, 1'b0);
  endtask

  task automatic proc_set(input bit we, input int unsigned a, input logic [DW-1:0] d, input bit dn);
    exp_t e;
    DataMemWrEn      = we;
    dataMemAddr      = AW'(a);
    ProcessorDataOut = d;
    done             = dn;
    if (we) model_wr(a, d);
    else if (is_known(a)) begin
      e.due  = cyc + 1;
      e.data = model_rd(a);
      pq.push_back(e);
    end
  endtask

`ifdef DATA_MEM_CTRL_CLEAR_EN
  task automatic wait_clear();
    int unsigned n = 0;
    for (int unsigned i = 0; i < DEPTH + 20; i++) begin
      @(negedge clk);
      if (!busy) break;
      if (i == 0) chk("clear_wr_ready", 64'(host_wr_ready), 64'(0));
      n++;
    end
    chk("clear_busy_cycles", 64'(n), 64'(DEPTH));
    tick();
  endtask
`endif

  initial begin
`ifdef DATA_MEM_CTRL_CLEAR_EN
    clear_mode = 1'b1;
`else
    clear_mode = 1'b0;
`endif
    exp_host = 1'b0;
    rstN = 1'b0;
    host_wr_valid = 1'b0; host_wr_addr = '0; host_wr_data = '0;
    host_rd_req = 1'b0; host_rd_addr = '0; host_go = 1'b0;
    ready = 1'b1; done = 1'b0;
    dataMemAddr = '0; DataMemWrEn = 1'b0; ProcessorDataOut = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_start", 64'(start), 64'(0));
    chk("rst_busy", 64'(busy), 64'(clear_mode));
    chk("rst_run_cycles", 64'(run_cycles), 64'(0));
    chk("rst_rd_valid", 64'(host_rd_valid), 64'(0));
    chk("rst_rd_data", 64'(host_rd_data), 64'(0));
    chk("rst_proc_in", 64'(ProcessorDataIn), 64'(0));
    chk("rst_wr_ready", 64'(host_wr_ready), 64'(!clear_mode));
    tick();
    rstN = 1'b1;
`ifdef DATA_MEM_CTRL_CLEAR_EN
    wait_clear();
    exp_host = 1'b1;
    for (int i = 0; i < 8; i++) drive_host(1'b0, 0, '0, 1'b1, (i == 0) ? DEPTH - 1 : $urandom_range(DEPTH - 1), 1'b0);
`else
    exp_host = 1'b1;
`endif

    // Basic write then read back
    drive_host(1'b1, 0, 48'h003, 1'b0, 0, 1'b0);
    drive_host(1'b1, 9, 48'hABC_DEF_012_345, 1'b0, 0, 1'b0);
    drive_host(1'b0, 0, '0, 1'b1, 0, 1'b0);
    drive_host(1'b0, 0, '0, 1'b1, 9, 1'b0);
    host_idle();

    // Same-cycle write/read collision: write wins, read retried next cycle
    drive_host(1'b1, 5, 48'h111, 1'b1, 5, 1'b0);
    drive_host(1'b0, 0, '0, 1'b1, 5, 1'b0);
    host_idle();

    // Randomized host traffic, including the top address
    for (int i = 0; i < 80; i++) begin
      int unsigned wa, ra;
      wa = ($urandom_range(7) == 0) ? DEPTH - 1 : $urandom_range(31);
      ra = known[$urandom_range(known.size() - 1)];
      drive_host(1'($urandom_range(1)), wa, rnd_data(), 1'($urandom_range(1)), ra, 1'b0);
    end
    host_idle();

    // Go with a read accepted in the last HOST cycle
    drive_host(1'b0, 0, '0, 1'b1, 9, 1'b1);
    host_go = 1'b0; host_rd_req = 1'b1; host_rd_addr = AW'(9);
    for (int k = 0; k < 4; k++) begin
      ready = (k < 3);
      @(negedge clk);
      chk("start_high", 64'(start), 64'(1));
      chk("start_busy", 64'(busy), 64'(1));
      if (k == 0) begin
        chk("start_wr_ready", 64'(host_wr_ready), 64'(0));
        chk("start_rd_ready", 64'(host_rd_ready), 64'(0));
      end
      tick();
    end
    host_rd_req = 1'b0;

    // RUN for 100 cycles with processor traffic; host write ignored
    for (int i = 0; i < 100; i++) begin
      if (i == 0) proc_set(1'b1, 20, 48'h555, 1'b0);
      else if (i == 1) proc_set(1'b0, 20, '0, 1'b0);
      else if ($urandom_range(2) == 0) proc_set(1'b1, $urandom_range(32, 63), rnd_data(), i == 99);
      else proc_set(1'b0, known[$urandom_range(known.size() - 1)], '0, i == 99);
      host_wr_valid = (i == 5);
      host_wr_addr  = AW'(20);
      host_wr_data  = 48'hBAD;
      @(negedge clk);
      if (i == 0) chk("run_start_low", 64'(start), 64'(0));
      if (i == 5) chk("run_wr_ready", 64'(host_wr_ready), 64'(0));
      if (i == 50) chk("run_busy", 64'(busy), 64'(1));
      tick();
    end
    done = 1'b0; DataMemWrEn = 1'b0; host_wr_valid = 1'b0; ready = 1'b1;
    exp_host = 1'b1;
    @(negedge clk);
    chk("after_run_busy", 64'(busy), 64'(0));
    chk("run_cycles_100", 64'(run_cycles), 64'(100));
    tick();
    // Processor inputs ignored in HOST
    DataMemWrEn = 1'b1; dataMemAddr = AW'(9); ProcessorDataOut = 48'hDEAD;
    drive_host(1'b0, 0, '0, 1'b1, 20, 1'b0);
    chk("host_proc_in_zero", 64'(ProcessorDataIn), 64'(0));
    drive_host(1'b0, 0, '0, 1'b1, 9, 1'b0);
    DataMemWrEn = 1'b0;
    drive_host(1'b0, 0, '0, 1'b1, 9, 1'b0);
    drive_host(1'b0, 0, '0, 1'b1, 0, 1'b0);
    host_idle();

    // done already high on RUN entry -> one-cycle run
    drive_host(1'b0, 0, '0, 1'b0, 0, 1'b1);
    host_go = 1'b0; ready = 1'b0; done = 1'b1;
    @(negedge clk);
    chk("short_start", 64'(start), 64'(1));
    tick();
    @(negedge clk);
    chk("short_run_busy", 64'(busy), 64'(1));
    tick();
    done = 1'b0; ready = 1'b1;
    exp_host = 1'b1;
    @(negedge clk);
    chk("short_busy", 64'(busy), 64'(0));
    chk("run_cycles_1", 64'(run_cycles), 64'(1));
    tick();

    // Reset in the middle of a run
    drive_host(1'b0, 0, '0, 1'b0, 0, 1'b1);
    host_go = 1'b0; ready = 1'b0;
    tick();
    proc_set(1'b1, 40, 48'h777, 1'b0);
    tick();
    proc_set(1'b1, 41, rnd_data(), 1'b0);
    tick();
    DataMemWrEn = 1'b0;
    #2 rstN = 1'b0;
    #1;
    chk("midrst_start", 64'(start), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(clear_mode));
    chk("midrst_proc_in", 64'(ProcessorDataIn), 64'(0));
    chk("midrst_run_cycles", 64'(run_cycles), 64'(0));
    hq.delete(); pq.delete();
    ready = 1'b1; done = 1'b0;
    exp_host = 1'b0;
    tick(); tick();
    rstN = 1'b1;
`ifdef DATA_MEM_CTRL_CLEAR_EN
    model.delete();
    known.delete();
    wait_clear();
`endif
    exp_host = 1'b1;
    drive_host(1'b0, 0, '0, 1'b1, 40, 1'b0);
    drive_host(1'b1, 50, 48'h123_456_789_ABC, 1'b0, 0, 1'b0);
    drive_host(1'b0, 0, '0, 1'b1, 50, 1'b0);
    repeat (3) host_idle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Global time limit
  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
